// File: rtl/conv_out_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conv_out_buf_pkg                                              |
// | Purpose  : Shared definitions for the convolution output buffer: data    |
// |            word width, FSM state encoding and the result-map side-length |
// |            helper used by the integrator.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package conv_out_buf_pkg;

    // Data word width.
    localparam int DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Side length of the stored map: maxpool halves the conv output size.
    function automatic int res_size(input int conv_size, input bit maxpool_en);
        return maxpool_en ? (conv_size / 2) : conv_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_out_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conv_out_ram                                                  |
// | Purpose  : Simple dual-port RAM, one write port and one registered read  |
// |            port (1-cycle read latency), inferable as block RAM.          |
// | Ports    : clk                      - clock                              |
// |            we / wr_addr / wr_data   - write port                         |
// |            re / rd_addr             - read request                       |
// |            rd_data                  - read data, valid the cycle after re |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module conv_out_ram #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // No reset on the array or read register so the tools map it to BRAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      if (re) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_out_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conv_out_buf                                                  |
// | Purpose  : Captures the conv result stream (i_en/i_data) into BRAM in    |
// |            raster order, then drains the full map over a valid/ready     |
// |            stream through a 2-entry skid. Flags completion and overflow. |
// | Ports    : i_clk, i_rst   - clock, synchronous active-high reset         |
// |            i_go           - start a capture (honoured in IDLE/DONE)      |
// |            i_en, i_data   - result write strobe and signed data word     |
// |            o_rd_valid, o_rd_data, i_rd_ready - output stream             |
// |            o_full         - map captured, drain pending/in progress      |
// |            o_done         - all words handed off                         |
// |            o_overflow     - sticky, write strobe seen outside FILL       |
// |            o_wr_cnt       - words written in the current capture         |
// |            o_checksum     - only with CONV_OUT_BUF_CHECKSUM_EN defined:  |
// |                             32-bit wrap-around sum of captured words     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module conv_out_buf #(
   parameter  int DW       = conv_out_buf_pkg::DW,
   parameter  int RES_SIZE = 13,
   localparam int DEPTH    = RES_SIZE * RES_SIZE,
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_go,
   input  logic          i_en,
   input  logic [DW-1:0] i_data,
   output logic          o_rd_valid,
   output logic [DW-1:0] o_rd_data,
   input  logic          i_rd_ready,
   output logic          o_full,
   output logic          o_done,
   output logic          o_overflow,
`ifdef CONV_OUT_BUF_CHECKSUM_EN
   output logic [31:0]   o_checksum,
`endif
   output logic [AW:0]   o_wr_cnt
);

   import conv_out_buf_pkg::*;

   localparam logic [AW:0]   LAST_CNT  = (AW+1)'(DEPTH - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        state;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          rd_all_issued;   // every address has been read from BRAM
   logic          rd_pend;         // BRAM read data lands this cycle
   logic [1:0]    sk_cnt;          // skid occupancy (head is o_rd_data)
   logic [DW-1:0] sk_tail;
   logic [AW:0]   hs_cnt;          // handshakes completed

   logic          wr_en;
   logic          rd_en;
   logic          pop;
   logic          push;
   logic [1:0]    sk_cnt_nxt;
   logic [DW-1:0] ram_q;

   always_comb begin
      wr_en      = (state == ST_FILL) && i_en;
      pop        = o_rd_valid && i_rd_ready;
      push       = rd_pend;
      sk_cnt_nxt = sk_cnt + {1'b0, push} - {1'b0, pop};
      // A read issued now lands next cycle; only issue if the skid will have
      // room even if nothing is popped then. With ready held high this still
      // settles at one read, one push and one pop per cycle.
      rd_en      = (state == ST_DRAIN) && !rd_all_issued && (sk_cnt_nxt < 2'd2);
   end

   conv_out_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk     (i_clk),
      .we      (wr_en),
      .wr_addr (wr_addr),
      .wr_data (i_data),
      .re      (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         wr_addr       <= '0;
         rd_addr       <= '0;
         rd_all_issued <= 1'b0;
         rd_pend       <= 1'b0;
         sk_cnt        <= '0;
         sk_tail       <= '0;
         hs_cnt        <= '0;
         o_rd_valid    <= 1'b0;
         o_rd_data     <= '0;
         o_full        <= 1'b0;
         o_done        <= 1'b0;
         o_overflow    <= 1'b0;
         o_wr_cnt      <= '0;
`ifdef CONV_OUT_BUF_CHECKSUM_EN
         o_checksum    <= '0;
`endif
      end else begin
         rd_pend <= rd_en;

         // Strobes outside FILL are dropped (never written) and flagged.
         if (i_en && (state != ST_FILL)) begin
            o_overflow <= 1'b1;
         end

         case (state)
            ST_IDLE, ST_DONE: begin
               if (i_go) begin
                  state         <= ST_FILL;
                  wr_addr       <= '0;
                  rd_addr       <= '0;
                  rd_all_issued <= 1'b0;
                  hs_cnt        <= '0;
                  o_wr_cnt      <= '0;
                  o_done        <= 1'b0;
`ifdef CONV_OUT_BUF_CHECKSUM_EN
                  o_checksum    <= '0;
`endif
               end
            end

            ST_FILL: begin
               if (i_en) begin
                  o_wr_cnt <= o_wr_cnt + (AW+1)'(1);
`ifdef CONV_OUT_BUF_CHECKSUM_EN
                  o_checksum <= o_checksum + 32'($signed(i_data));
`endif
                  // The last write ends the fill; wr_addr stays at DEPTH-1.
                  if (o_wr_cnt == LAST_CNT) begin
                     state  <= ST_DRAIN;
                     o_full <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr + AW'(1);
                  end
               end
            end

            ST_DRAIN: begin
               if (rd_en) begin
                  if (rd_addr == LAST_ADDR) begin
                     rd_all_issued <= 1'b1;
                  end else begin
                     rd_addr <= rd_addr + AW'(1);
                  end
               end

               sk_cnt     <= sk_cnt_nxt;
               o_rd_valid <= (sk_cnt_nxt != 2'd0);
               case ({push, pop})
                  2'b11: begin
                     if (sk_cnt == 2'd2) begin
                        o_rd_data <= sk_tail;
                        sk_tail   <= ram_q;
                     end else begin
                        o_rd_data <= ram_q;
                     end
                  end
                  2'b10: begin
                     if (sk_cnt == 2'd0) begin
                        o_rd_data <= ram_q;
                     end else begin
                        sk_tail <= ram_q;
                     end
                  end
                  2'b01: begin
                     o_rd_data <= sk_tail;
                  end
                  default: begin
                  end
               endcase

               if (pop) begin
                  hs_cnt <= hs_cnt + (AW+1)'(1);
                  if (hs_cnt == LAST_CNT) begin
                     state  <= ST_DONE;
                     o_full <= 1'b0;
                     o_done <= 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_out_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_conv_out_buf                                               |
// | Purpose  : Self-checking bench for conv_out_buf (RES_SIZE=3). A queue    |
// |            model holds the captured words in write order; every drained  |
// |            word must match the queue head. Define                        |
// |            CONV_OUT_BUF_CHECKSUM_EN to also check o_checksum.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_conv_out_buf;
   import conv_out_buf_pkg::*;

   localparam int RS  = 3;
   localparam int N   = RS * RS;
   localparam int AWT = $clog2(N);

   logic                 i_clk = 1'b0;
   logic                 i_rst = 1'b1;
   logic                 i_go = 1'b0;
   logic                 i_en = 1'b0;
   logic [DW-1:0]        i_data = '0;
   logic                 i_rd_ready = 1'b0;
   logic                 o_rd_valid;
   logic [DW-1:0]        o_rd_data;
   logic                 o_full;
   logic                 o_done;
   logic                 o_overflow;
   logic [AWT:0]         o_wr_cnt;
`ifdef CONV_OUT_BUF_CHECKSUM_EN
   logic [31:0]          o_checksum;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic signed [DW-1:0] exp_q[$];
   logic                 exp_ovf = 1'b0;
   int                   exp_sum = 0;

   conv_out_buf #(
      .RES_SIZE (RS)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_go       (i_go),
      .i_en       (i_en),
      .i_data     (i_data),
      .o_rd_valid (o_rd_valid),
      .o_rd_data  (o_rd_data),
      .i_rd_ready (i_rd_ready),
      .o_full     (o_full),
      .o_done     (o_done),
      .o_overflow (o_overflow),
`ifdef CONV_OUT_BUF_CHECKSUM_EN
      .o_checksum (o_checksum),
`endif
      .o_wr_cnt   (o_wr_cnt)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_go = 1'b0;
      i_en = 1'b0;
      i_rd_ready = 1'b0;
      tick();
      i_rst = 1'b0;
      exp_ovf = 1'b0;
      exp_q = {};
   endtask

   task automatic test_reset();
      vectors++;
      if (o_rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", o_rd_valid); end
      vectors++;
      if (o_rd_data !== '0) begin miscompares++; $display("FAIL reset_data: got %0h want 0", o_rd_data); end
      vectors++;
      if (o_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", o_full); end
      vectors++;
      if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", o_done); end
      vectors++;
      if (o_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
      vectors++;
      if (o_wr_cnt !== '0) begin miscompares++; $display("FAIL reset_wr_cnt: got %0d want 0", o_wr_cnt); end
   endtask

   // Start a capture and write vals. gap = k writes every k-th cycle,
   // gap = 0 picks a random 1..3 spacing per word.
   task automatic fill(input logic signed [DW-1:0] vals[$], input int gap, input bit go_with_en);
      int g;
      exp_q = {};
      exp_sum = 0;
      i_go = 1'b1;
      i_en = go_with_en;
      i_data = DW'(99);
      if (go_with_en) exp_ovf = 1'b1;
      tick();
      i_go = 1'b0;
      i_en = 1'b0;
      vectors++;
      if (o_wr_cnt !== '0 || o_done !== 1'b0 || o_full !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_start: wr_cnt=%0d done=%b full=%b want 0/0/0", o_wr_cnt, o_done, o_full);
      end
      for (int k = 0; k < vals.size(); k++) begin
         g = (gap == 0) ? int'($urandom_range(1, 3)) : gap;
         repeat (g - 1) tick();
         i_en = 1'b1;
         i_data = vals[k];
         tick();
         i_en = 1'b0;
         exp_q.push_back(vals[k]);
         exp_sum += int'(vals[k]);
         vectors++;
         if (o_wr_cnt !== (AWT+1)'(k + 1)) begin
            miscompares++;
            $display("FAIL wr_cnt: got %0d want %0d", o_wr_cnt, k + 1);
         end
         vectors++;
         if (o_full !== (k == N - 1)) begin
            miscompares++;
            $display("FAIL full_rise: after write %0d got %b want %b", k + 1, o_full, (k == N - 1));
         end
      end
`ifdef CONV_OUT_BUF_CHECKSUM_EN
      vectors++;
      if (o_checksum !== 32'(exp_sum)) begin
         miscompares++;
         $display("FAIL checksum: got %0d want %0d", $signed(o_checksum), exp_sum);
      end
`endif
   endtask

   // mode 0: ready high, 1: ready 1,0,0 pattern, 2: random ready.
   task automatic drain(input int mode, input bit inject, input int max_hs);
      int   cyc = 0;
      int   hs = 0;
      int   first_valid = -1;
      bit   prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      bit   rdy;
      while (hs < max_hs && exp_q.size() > 0 && cyc < 200) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         i_rd_ready = rdy;
         i_en = inject && ($urandom_range(0, 3) == 0);
         i_data = DW'(99);
         if (i_en) exp_ovf = 1'b1;
         if (prev_stall) begin
            vectors++;
            if (o_rd_valid !== 1'b1 || o_rd_data !== prev_data) begin
               miscompares++;
               $display("FAIL stall_hold: valid=%b data=%0d want 1/%0d", o_rd_valid, $signed(o_rd_data), $signed(prev_data));
            end
         end
         if (o_rd_valid === 1'b1) begin
            if (first_valid < 0) first_valid = cyc;
            vectors++;
            if (o_rd_data !== exp_q[0]) begin
               miscompares++;
               $display("FAIL rd_data: word %0d got %0d want %0d", N - exp_q.size(), $signed(o_rd_data), exp_q[0]);
            end
            if (rdy) begin
               void'(exp_q.pop_front());
               hs++;
            end
         end
         prev_stall = (o_rd_valid === 1'b1) && !rdy;
         prev_data = o_rd_data;
         tick();
         cyc++;
      end
      i_en = 1'b0;
      i_rd_ready = 1'b0;
      if (cyc >= 200) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d handshakes want %0d", hs, max_hs);
      end
      vectors++;
      if (first_valid < 0 || first_valid > 2) begin
         miscompares++;
         $display("FAIL first_valid_latency: got %0d cycles want <=2", first_valid);
      end
      if (exp_q.size() == 0) begin
         vectors++;
         if (o_rd_valid !== 1'b0 || o_full !== 1'b0 || o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end: valid=%b full=%b done=%b want 0/0/1", o_rd_valid, o_full, o_done);
         end
         vectors++;
         if (o_overflow !== exp_ovf) begin
            miscompares++;
            $display("FAIL overflow_flag: got %b want %b", o_overflow, exp_ovf);
         end
      end
   endtask

   function automatic void seq(ref logic signed [DW-1:0] v[$], input int start);
      v = {};
      for (int i = 0; i < N; i++) v.push_back(DW'(start + i));
   endfunction

   task automatic test_fill_stream();
      logic signed [DW-1:0] v[$];
      seq(v, 1);
      fill(v, 1, 1'b0);
      drain(0, 1'b0, N);
   endtask

   task automatic test_back_pressure();
      logic signed [DW-1:0] v[$];
      seq(v, 1);
      fill(v, 1, 1'b0);
      drain(1, 1'b0, N);
   endtask

   task automatic test_gapped();
      logic signed [DW-1:0] v[$];
      seq(v, -5);
      fill(v, 3, 1'b0);
      drain(2, 1'b0, N);
   endtask

   task automatic test_overflow();
      logic signed [DW-1:0] v[$];
      do_reset();
      i_en = 1'b1;
      i_data = DW'(99);
      tick();
      i_en = 1'b0;
      exp_ovf = 1'b1;
      vectors++;
      if (o_overflow !== 1'b1 || o_wr_cnt !== '0) begin
         miscompares++;
         $display("FAIL idle_overflow: ovf=%b wr_cnt=%0d want 1/0", o_overflow, o_wr_cnt);
      end
      seq(v, 1);
      fill(v, 1, 1'b1);
      drain(0, 1'b1, N);
   endtask

   task automatic test_reset_mid_drain();
      logic signed [DW-1:0] v[$];
      seq(v, 1);
      fill(v, 1, 1'b0);
      drain(0, 1'b0, 4);
      do_reset();
      test_reset();
      seq(v, 10);
      fill(v, 1, 1'b0);
      drain(0, 1'b0, N);
   endtask

   task automatic test_random();
      logic signed [DW-1:0] v[$];
      for (int r = 0; r < 6; r++) begin
         v = {};
         for (int i = 0; i < N; i++) v.push_back(DW'($urandom));
         fill(v, 0, 1'($urandom_range(0, 1)));
         drain(2, 1'($urandom_range(0, 1)), N);
      end
   endtask

`ifdef CONV_OUT_BUF_CHECKSUM_EN
   task automatic test_checksum();
      logic signed [DW-1:0] v[$];
      seq(v, 1);
      fill(v, 1, 1'b0);
      vectors++;
      if (o_checksum !== 32'd45) begin miscompares++; $display("FAIL checksum_45: got %0d want 45", $signed(o_checksum)); end
      drain(0, 1'b0, N);
      v = {};
      for (int i = 0; i < N; i++) v.push_back(-DW'(1));
      fill(v, 1, 1'b0);
      vectors++;
      if (o_checksum !== -32'sd9) begin miscompares++; $display("FAIL checksum_m9: got %0d want -9", $signed(o_checksum)); end
      drain(0, 1'b0, N);
   endtask
`endif

   initial begin
      do_reset();
      test_reset();
      test_fill_stream();
      test_back_pressure();
      test_gapped();
      test_overflow();
      test_reset_mid_drain();
      test_random();
`ifdef CONV_OUT_BUF_CHECKSUM_EN
      test_checksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
